// File: rtl/pulse_stretch_if.sv
// Event/level bundle between the pulse source and the pulse stretcher.
// Latency: none, wires only.
// Backpressure: none; the stretcher queues events internally.
interface pulse_stretch_if #(
  parameter int PEND_W = 3
);
  logic              in_pulse;
  logic              clr_ovf;
  logic              out_level;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  // Event source side: drives strobes, observes the stretched level and status.
  modport master (
    output in_pulse, clr_ovf,
    input  out_level, busy, pending, overflow
  );

  // Stretcher side.
  modport slave (
    input  in_pulse, clr_ovf,
    output out_level, busy, pending, overflow
  );
endinterface

// File: rtl/pulse_stretch.sv
// Stretches single-cycle events into HOLD_CYCLES high windows separated by GAP_CYCLES low gaps.
// Latency: out_level rises one cycle after the accepted event; all outputs registered.
// Backpressure: none; extra events queue in a saturating counter, drops set sticky overflow.
// Optional feature macro PULSE_STRETCH_RETRIGGER_EN: a pulse during HIGH extends the window.
module pulse_stretch #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_W      = 3
) (
  input  logic           clk,
  input  logic           rst_n,  // active-high synchronous reset despite the name
  pulse_stretch_if.slave bus
);

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              ovf_q, ovf_d;
  logic              out_level_q, busy_q;
  logic              queue_ev;
  logic              drop;

  // Next-state, counter, pending-queue and overflow decisions.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    queue_ev = 1'b0;
    drop     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_pulse) begin
          state_d = HIGH;
          cnt_d   = HOLD_LOAD;
        end
      end

      HIGH: begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
        // A new event restarts the window, including on its last cycle.
        if (bus.in_pulse) begin
          cnt_d = HOLD_LOAD;
        end else if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`else
        queue_ev = bus.in_pulse;
        if (cnt_q == '0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
`endif
      end

      GAP: begin
        if (cnt_q == '0) begin
          // Terminal gap cycle: a fresh pulse and a queued replay cancel out,
          // so this cycle never touches the queue limit.
          if ((pend_q != '0) || bus.in_pulse) begin
            state_d = HIGH;
            cnt_d   = HOLD_LOAD;
            if ((pend_q != '0) && !bus.in_pulse) begin
              pend_d = pend_q - 1'b1;
            end
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d    = cnt_q - 1'b1;
          queue_ev = bus.in_pulse;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (queue_ev) begin
      if (pend_q != PEND_MAX) begin
        pend_d = pend_q + 1'b1;
      end else begin
        drop = 1'b1;
      end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State and registered outputs; reset aborts any window immediately.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pend_q      <= '0;
      ovf_q       <= 1'b0;
      out_level_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      ovf_q       <= ovf_d;
      out_level_q <= (state_d == HIGH);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign bus.out_level = out_level_q;
  assign bus.busy      = busy_q;
  assign bus.pending   = pend_q;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Self-checking bench for pulse_stretch with HOLD=4, GAP=2, PEND_W=3.
// Every cycle's expected outputs come from a reference model through a scoreboard queue;
// directed traces check the windows, queue depth and flag timing of each scenario.
module tb_pulse_stretch;

  localparam int HOLD = 4;
  localparam int GAP  = 2;
  localparam int PW   = 3;
  localparam int PMAX = (1 << PW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  pulse_stretch_if #(.PEND_W(PW)) bus ();

  pulse_stretch #(
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAP),
    .PEND_W     (PW)
  ) dut (
    .clk  (clk),
    .rst_n(rst),
    .bus  (bus)
  );

  typedef struct packed {
    logic          out;
    logic          busy;
    logic [PW-1:0] pend;
    logic          ovf;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: phase 0=idle, 1=high, 2=gap.
  int m_phase = 0;
  int m_cnt   = 0;
  int m_pend  = 0;
  bit m_ovf   = 1'b0;

  // Traces indexed by the cycle in which a value is visible.
  logic [127:0] out_tr, busy_tr, ovf_tr;
  int           pend_tr[128];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic queue_event();
    if (m_pend < PMAX) m_pend++;
    else m_ovf = 1'b1;
  endtask

  // Advances the model by one clock edge and pushes the expected outputs.
  task automatic model_step(input bit p, input bit c, input bit r);
    exp_t e;
    bit   ovf_before;
    if (r) begin
      m_phase = 0; m_cnt = 0; m_pend = 0; m_ovf = 1'b0;
    end else begin
      ovf_before = m_ovf;
      if (c) m_ovf = 1'b0;
      if (m_phase == 0) begin
        if (p) begin m_phase = 1; m_cnt = HOLD - 1; end
      end else if (m_phase == 1) begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
        if (p) m_cnt = HOLD - 1;
        else if (m_cnt == 0) begin m_phase = 2; m_cnt = GAP - 1; end
        else m_cnt--;
`else
        if (p) queue_event();
        if (m_cnt == 0) begin m_phase = 2; m_cnt = GAP - 1; end
        else m_cnt--;
`endif
      end else begin
        if (m_cnt != 0) begin
          m_cnt--;
          if (p) queue_event();
        end else if (m_pend > 0) begin
          m_phase = 1; m_cnt = HOLD - 1;
          if (!p) m_pend--;
        end else if (p) begin
          m_phase = 1; m_cnt = HOLD - 1;
        end else begin
          m_phase = 0;
        end
      end
      if (ovf_before && !c) m_ovf = 1'b1;
    end
    e.out  = (m_phase == 1);
    e.busy = (m_phase != 0);
    e.pend = PW'(m_pend);
    e.ovf  = m_ovf;
    sb_q.push_back(e);
  endtask

  // Runs n cycles; bit c of each mask is the input applied during cycle c.
  task automatic run(input logic [127:0] pm, input logic [127:0] cm,
                     input logic [127:0] rm, input int n);
    exp_t e;
    out_tr  = '0;
    busy_tr = '0;
    ovf_tr  = '0;
    for (int i = 0; i < 128; i++) pend_tr[i] = 0;
    for (int c = 0; c < n; c++) begin
      bus.in_pulse = pm[c];
      bus.clr_ovf  = cm[c];
      rst          = rm[c];
      model_step(pm[c], cm[c], rm[c]);
      @(posedge clk);
      @(negedge clk);
      if (sb_q.size() == 0) begin
        chk("sb_empty", 128'(1), 128'(0));
      end else begin
        e = sb_q.pop_front();
        chk("sb_out",  128'(bus.out_level), 128'(e.out));
        chk("sb_busy", 128'(bus.busy),      128'(e.busy));
        chk("sb_pend", 128'(bus.pending),   128'(e.pend));
        chk("sb_ovf",  128'(bus.overflow),  128'(e.ovf));
      end
      out_tr[c+1]    = bus.out_level;
      busy_tr[c+1]   = bus.busy;
      ovf_tr[c+1]    = bus.overflow;
      pend_tr[c+1]   = int'(bus.pending);
    end
  endtask

  function automatic int count_windows(input int n);
    int w = 0;
    for (int c = 1; c <= n; c++) if (out_tr[c] && !out_tr[c-1]) w++;
    return w;
  endfunction

  function automatic int pend_or(input int n);
    int acc = 0;
    for (int c = 0; c <= n; c++) acc |= pend_tr[c];
    return acc;
  endfunction

  initial begin
    logic [127:0] pm, cm, rm, m;

    bus.in_pulse = 1'b0;
    bus.clr_ovf  = 1'b0;

    // Single event: window 11-14, gap 15-16, idle from 17.
    rm = 128'h3; cm = '0;
    pm = 128'h1 << 10;
    run(pm, cm, rm, 24);
    chk("s1_reset_out",  128'(out_tr[2]),  128'(0));
    chk("s1_reset_busy", 128'(busy_tr[2]), 128'(0));
    chk("s1_reset_pend", 128'(pend_tr[2]), 128'(0));
    chk("s1_reset_ovf",  128'(ovf_tr[2]),  128'(0));
    m = 128'hF << 11;
    chk("s1_out_trace", out_tr, m);
    m = 128'h3F << 11;
    chk("s1_busy_trace", busy_tr, m);
    chk("s1_pend_zero", 128'(pend_or(24)), 128'(0));

    // Pulse on the terminal gap cycle restarts directly without queueing.
    pm = (128'h1 << 10) | (128'h1 << 16);
    run(pm, cm, rm, 28);
    m = (128'hF << 11) | (128'hF << 17);
    chk("s3_out_trace", out_tr, m);
    chk("s3_pend_zero", 128'(pend_or(28)), 128'(0));

    // Three back-to-back events replay in order.
    pm = 128'h7 << 10;
    run(pm, cm, rm, 32);
`ifndef PULSE_STRETCH_RETRIGGER_EN
    m = (128'hF << 11) | (128'hF << 17) | (128'hF << 23);
    chk("s2_out_trace", out_tr, m);
    m = 128'h3FFFF << 11;
    chk("s2_busy_trace", busy_tr, m);
    chk("s2_pend_c12", 128'(pend_tr[12]), 128'(1));
    chk("s2_pend_c13", 128'(pend_tr[13]), 128'(2));
    chk("s2_pend_c17", 128'(pend_tr[17]), 128'(1));
    chk("s2_pend_c23", 128'(pend_tr[23]), 128'(0));
    chk("s2_busy_c29", 128'(busy_tr[29]), 128'(0));
`endif

    // Eleven consecutive events: queue saturates, two are dropped, one of
    // them together with a clear; a later lone clear resets the flag.
    pm = 128'h7FF << 10;
    cm = (128'h1 << 20) | (128'h1 << 30);
    run(pm, cm, rm, 72);
    cm = '0;
`ifndef PULSE_STRETCH_RETRIGGER_EN
    chk("s4_pend_c19", 128'(pend_tr[19]), 128'(PMAX));
    chk("s4_ovf_c19",  128'(ovf_tr[19]),  128'(0));
    chk("s4_ovf_c20",  128'(ovf_tr[20]),  128'(1));
    chk("s4_ovf_clr_vs_drop", 128'(ovf_tr[21]), 128'(1));
    chk("s4_ovf_c30",  128'(ovf_tr[30]),  128'(1));
    chk("s4_ovf_c31",  128'(ovf_tr[31]),  128'(0));
    chk("s4_windows",  128'(count_windows(72)), 128'(9));
    chk("s4_idle_busy", 128'(busy_tr[70]), 128'(0));
    chk("s4_idle_pend", 128'(pend_tr[70]), 128'(0));
`endif

    // Reset in the middle of a window with events queued; pulse in reset cycle ignored.
    pm = 128'hF << 9;
    rm = 128'h3 | (128'h1 << 12);
    run(pm, cm, rm, 20);
`ifndef PULSE_STRETCH_RETRIGGER_EN
    chk("s5_pend_c12", 128'(pend_tr[12]), 128'(2));
`endif
    chk("s5_out_c12",  128'(out_tr[12]),  128'(1));
    chk("s5_out_c13",  128'(out_tr[13]),  128'(0));
    chk("s5_busy_c13", 128'(busy_tr[13]), 128'(0));
    chk("s5_pend_c13", 128'(pend_tr[13]), 128'(0));
    chk("s5_ovf_c13",  128'(ovf_tr[13]),  128'(0));
    chk("s5_busy_c14", 128'(busy_tr[14]), 128'(0));

`ifdef PULSE_STRETCH_RETRIGGER_EN
    // A second event inside the window extends it.
    rm = 128'h3;
    pm = (128'h1 << 10) | (128'h1 << 13);
    run(pm, cm, rm, 24);
    m = 128'h7F << 11;
    chk("s6_out_trace", out_tr, m);
    m = 128'h1FF << 11;
    chk("s6_busy_trace", busy_tr, m);
    chk("s6_pend_zero", 128'(pend_or(24)), 128'(0));
`endif

    chk("sb_drained", 128'(sb_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
